// File: rtl/writeback_arbiter.sv
// Multi-source write-back unit: per-producer result FIFOs arbitrated onto the single
// register-file write port, which doubles as the W->E forwarding source.

module wb_src_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
endmodule

module writeback_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [NUM_SRC-1:0]      src_valid_i,
  output logic [NUM_SRC-1:0]      src_ready_o,
  input  logic [NUM_SRC-1:0]      src_we_i,
  input  logic [NUM_SRC*5-1:0]    src_rd_addr_i,
  input  logic [NUM_SRC*XLEN-1:0] src_data_i,
  output logic                    write_en_o,
  output logic [4:0]              rd_addr_o,
  output logic [XLEN-1:0]         rd_data_o,
  output logic [XLEN-1:0]         wb_data_fwd_o,
  output logic [4:0]              rd_addr_fwd_o,
  output logic                    reg_write_en_fwd_o,
  output logic                    busy_o
);
  localparam int EW = 5 + XLEN;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]         push, pop, grant, not_empty;
  logic [NUM_SRC-1:0][EW-1:0] head;
  logic [NUM_SRC-1:0][CW-1:0] count;
  logic [SW-1:0]              rr_ptr, gnt_idx;
  logic                       any_gnt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [4:0] addr;
    assign addr = src_rd_addr_i[5*g +: 5];

    // Ready looks only at occupancy: a full FIFO refuses even if its head leaves this cycle.
    assign src_ready_o[g] = rst_ni & (count[g] < CW'(BUF_DEPTH));
    assign push[g]      = src_valid_i[g] & src_ready_o[g] & src_we_i[g] & (addr != 5'd0) & ~flush_i;
    assign pop[g]       = grant[g] & ~flush_i;
    assign not_empty[g] = (count[g] != '0);

    wb_src_fifo #(.W(EW), .DEPTH(BUF_DEPTH), .CW(CW)) u_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .flush (flush_i),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata ({addr, src_data_i[XLEN*g +: XLEN]}),
      .rdata (head[g]),
      .count (count[g])
    );

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push[g] |-> (count[g] != CW'(BUF_DEPTH)));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count[g] <= CW'(BUF_DEPTH));
    a_src_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (src_valid_i[g] && !src_ready_o[g]) |=> (src_valid_i[g] && $stable(src_we_i[g]) &&
      $stable(src_rd_addr_i[5*g +: 5]) && $stable(src_data_i[XLEN*g +: XLEN])));
  end

  // Scan starts at rr_ptr in round-robin mode, at 0 in fixed mode.
  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (PRIO_MODE == 1) ? int'(rr_ptr) + k : k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!any_gnt && not_empty[idx]) begin
        any_gnt    = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      rr_ptr <= '0;
    else if (!flush_i && any_gnt && PRIO_MODE == 1)
      rr_ptr <= (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_en_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else if (flush_i) begin
      write_en_o <= 1'b0;
    end else begin
      write_en_o <= any_gnt;
      if (any_gnt) {rd_addr_o, rd_data_o} <= head[gnt_idx];
    end
  end

  assign wb_data_fwd_o      = rd_data_o;
  assign rd_addr_fwd_o      = rd_addr_o;
  assign reg_write_en_fwd_o = write_en_o;
  assign busy_o             = (|not_empty) | write_en_o;

  a_we_addr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    write_en_o |-> (rd_addr_o != 5'd0));
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: one fixed-priority and one round-robin instance.

module tb_writeback_arbiter;
  localparam int NS = 4;
  localparam int XL = 32;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0]    valid, we, ready;
  logic [NS*5-1:0]  rd;
  logic [NS*XL-1:0] data;
  logic             wen, fwd_en, busy;
  logic [4:0]       addr, fwd_addr;
  logic [XL-1:0]    wdat, fwd_dat;

  logic [NS-1:0]    r_valid, r_we, r_ready;
  logic [NS*5-1:0]  r_rd;
  logic [NS*XL-1:0] r_data;
  logic             r_wen, r_fwd_en, r_busy;
  logic [4:0]       r_addr, r_fwd_addr;
  logic [XL-1:0]    r_wdat, r_fwd_dat;

  int total = 0, bad = 0;
  logic [36:0] exp_q[$], obs_q[$];
  logic [4:0]  rr_obs[$];

  writeback_arbiter #(.NUM_SRC(NS), .XLEN(XL), .BUF_DEPTH(2), .PRIO_MODE(0)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .src_valid_i(valid), .src_ready_o(ready), .src_we_i(we),
    .src_rd_addr_i(rd), .src_data_i(data),
    .write_en_o(wen), .rd_addr_o(addr), .rd_data_o(wdat),
    .wb_data_fwd_o(fwd_dat), .rd_addr_fwd_o(fwd_addr), .reg_write_en_fwd_o(fwd_en),
    .busy_o(busy));

  writeback_arbiter #(.NUM_SRC(NS), .XLEN(XL), .BUF_DEPTH(2), .PRIO_MODE(1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .src_valid_i(r_valid), .src_ready_o(r_ready), .src_we_i(r_we),
    .src_rd_addr_i(r_rd), .src_data_i(r_data),
    .write_en_o(r_wen), .rd_addr_o(r_addr), .rd_data_o(r_wdat),
    .wb_data_fwd_o(r_fwd_dat), .rd_addr_fwd_o(r_fwd_addr), .reg_write_en_fwd_o(r_fwd_en),
    .busy_o(r_busy));

  // Monitor: record every write-port pulse
  always @(negedge clk) begin
    if (wen)   obs_q.push_back({addr, wdat});
    if (r_wen) rr_obs.push_back(r_addr);
  end

  task automatic drive(input int i, input logic v, input logic w, input logic [4:0] a,
                       input logic [XL-1:0] d);
    valid[i] = v; we[i] = w; rd[5*i +: 5] = a; data[XL*i +: XL] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NS; i++) drive(i, 1'b0, 1'b0, 5'd0, '0);
  endtask

  task automatic test_reset();
    #2;
    total++; if ({wen, addr, wdat, busy, ready} !== '0) begin bad++;
      $display("FAIL reset_out got=%h exp=0", {wen, addr, wdat, busy, ready}); end
    total++; if ({fwd_en, fwd_addr, fwd_dat, r_wen, r_ready, r_busy} !== '0) begin bad++;
      $display("FAIL reset_fwd got=%h exp=0", {fwd_en, fwd_addr, fwd_dat, r_wen, r_ready, r_busy}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({ready, r_ready, busy} !== 9'b1111_1111_0) begin bad++;
      $display("FAIL post_reset_ready got=%b exp=111111110", {ready, r_ready, busy}); end
  endtask

  task automatic test_single();
    int base = obs_q.size();
    logic [36:0] e, o;
    drive(0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk);                       // edge 0 accepted
    idle_all();
    total++; if ({wen, busy} !== 2'b01) begin bad++;
      $display("FAIL single_lat1 got=%b exp=01", {wen, busy}); end
    @(negedge clk);                       // edge 1 granted
    total++; if ({wen, addr, wdat} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin bad++;
      $display("FAIL single_port got=%h exp=%h", {wen, addr, wdat}, {1'b1, 5'd5, 32'hDEADBEEF}); end
    total++; if ({fwd_en, fwd_addr, fwd_dat} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin bad++;
      $display("FAIL single_fwd got=%h exp=%h", {fwd_en, fwd_addr, fwd_dat}, {1'b1, 5'd5, 32'hDEADBEEF}); end
    @(negedge clk);
    total++; if ({wen, busy} !== 2'b00) begin bad++;
      $display("FAIL single_done got=%b exp=00", {wen, busy}); end
    #1;
    total++; if (obs_q.size() - base !== exp_q.size()) begin bad++;
      $display("FAIL single_sb_cnt got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (base < obs_q.size()) ? obs_q[base] : 'x; base++;
      total++; if (o !== e) begin bad++; $display("FAIL single_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_discard();
    int base = obs_q.size();
    drive(1, 1'b1, 1'b1, 5'd0, 32'h1234);
    drive(2, 1'b1, 1'b0, 5'd9, 32'h55);
    @(negedge clk);
    idle_all();
    total++; if ({ready[2:1], wen, busy} !== 4'b1100) begin bad++;
      $display("FAIL discard_a got=%b exp=1100", {ready[2:1], wen, busy}); end
    @(negedge clk);
    total++; if ({ready[2:1], wen, busy} !== 4'b1100) begin bad++;
      $display("FAIL discard_b got=%b exp=1100", {ready[2:1], wen, busy}); end
    @(negedge clk); #1;
    total++; if (obs_q.size() - base !== 0) begin bad++;
      $display("FAIL discard_writes got=%0d exp=0", obs_q.size() - base); end
  endtask

  task automatic test_fixed_prio();
    int base = obs_q.size();
    logic [36:0] e, o;
    for (int i = 0; i < NS; i++) begin
      drive(i, 1'b1, 1'b1, 5'(i + 1), 32'(32'h100 + i));
      exp_q.push_back({5'(i + 1), 32'(32'h100 + i)});
    end
    @(negedge clk);
    idle_all();
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL prio_lat got=%b exp=0", wen); end
    for (int c = 0; c < NS; c++) begin
      @(negedge clk);
      total++; if ({wen, addr} !== {1'b1, 5'(c + 1)}) begin bad++;
        $display("FAIL prio_seq%0d got=%h exp=%h", c, {wen, addr}, {1'b1, 5'(c + 1)}); end
    end
    @(negedge clk); #1;
    total++; if (obs_q.size() - base !== exp_q.size()) begin bad++;
      $display("FAIL prio_sb_cnt got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (base < obs_q.size()) ? obs_q[base] : 'x; base++;
      total++; if (o !== e) begin bad++; $display("FAIL prio_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_backpressure();
    int base = obs_q.size();
    int a0 = 0, a3 = 0;
    logic [36:0] pend[$];
    logic [36:0] e, o;
    for (int c = 0; c < 8; c++) begin
      drive(0, 1'b1, 1'b1, 5'd3, 32'(32'hA000 + a0));
      if (a3 < 2) drive(3, 1'b1, 1'b1, 5'd7, 32'(32'h7000 + a3));
      else        drive(3, 1'b0, 1'b0, 5'd0, '0);
      if (valid[0] && ready[0]) begin exp_q.push_back({5'd3, 32'(32'hA000 + a0)}); a0++; end
      if (valid[3] && ready[3]) begin pend.push_back({5'd7, 32'(32'h7000 + a3)}); a3++; end
      @(negedge clk);
      if (c >= 1) begin
        total++; if (ready[3] !== 1'b0) begin bad++;
          $display("FAIL bp_ready3_c%0d got=%b exp=0", c, ready[3]); end
      end
    end
    idle_all();
    total++; if (a3 !== 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", a3); end
    while (pend.size() > 0) exp_q.push_back(pend.pop_front());
    repeat (6) @(negedge clk);
    total++; if ({ready[3], busy} !== 2'b10) begin bad++;
      $display("FAIL bp_idle got=%b exp=10", {ready[3], busy}); end
    #1;
    total++; if (obs_q.size() - base !== exp_q.size()) begin bad++;
      $display("FAIL bp_sb_cnt got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (base < obs_q.size()) ? obs_q[base] : 'x; base++;
      total++; if (o !== e) begin bad++; $display("FAIL bp_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_round_robin();
    int base = rr_obs.size();
    int left0 = 6, left2 = 6;
    for (int c = 0; c < 30; c++) begin
      r_valid[0] = (left0 > 0); r_we[0] = 1'b1; r_rd[0 +: 5]  = 5'd10; r_data[0 +: XL]    = 32'(6 - left0);
      r_valid[2] = (left2 > 0); r_we[2] = 1'b1; r_rd[10 +: 5] = 5'd12; r_data[2*XL +: XL] = 32'(6 - left2);
      if (r_valid[0] && r_ready[0]) left0--;
      if (r_valid[2] && r_ready[2]) left2--;
      @(negedge clk);
    end
    r_valid = '0;
    total++; if (left0 + left2 !== 0) begin bad++;
      $display("FAIL rr_timeout got=%0d exp=0", left0 + left2); end
    #1;
    total++; if (rr_obs.size() - base !== 12) begin bad++;
      $display("FAIL rr_count got=%0d exp=12", rr_obs.size() - base); end
    for (int k = 0; k < 8; k++) begin
      logic [4:0] g;
      g = (base + k < rr_obs.size()) ? rr_obs[base + k] : 'x;
      total++; if (g !== ((k % 2 == 1) ? 5'd12 : 5'd10)) begin bad++;
        $display("FAIL rr_grant%0d got=%0d exp=%0d", k, g, (k % 2 == 1) ? 12 : 10); end
    end
  endtask

  task automatic test_flush();
    int base = obs_q.size();
    logic [36:0] e, o;
    for (int i = 0; i < NS; i++) drive(i, 1'b1, 1'b1, 5'(16 + i), 32'(32'h200 + i));
    exp_q.push_back({5'd16, 32'h200});
    @(negedge clk);
    for (int i = 0; i < NS; i++) drive(i, 1'b1, 1'b1, 5'(16 + i), 32'(32'h210 + i));
    @(negedge clk);
    total++; if ({wen, addr} !== {1'b1, 5'd16}) begin bad++;
      $display("FAIL flush_pre got=%h exp=%h", {wen, addr}, {1'b1, 5'd16}); end
    flush = 1'b1;
    for (int i = 0; i < NS; i++)
      if (ready[i]) drive(i, 1'b1, 1'b1, 5'(16 + i), 32'(32'h220 + i));
      else          drive(i, 1'b0, 1'b0, 5'd0, '0);
    @(negedge clk);
    flush = 1'b0;
    idle_all();
    total++; if ({wen, busy, ready} !== 6'b00_1111) begin bad++;
      $display("FAIL flush_post got=%b exp=001111", {wen, busy, ready}); end
    drive(2, 1'b1, 1'b1, 5'd9, 32'h99);
    exp_q.push_back({5'd9, 32'h99});
    @(negedge clk);
    idle_all();
    repeat (3) @(negedge clk);
    #1;
    total++; if (obs_q.size() - base !== exp_q.size()) begin bad++;
      $display("FAIL flush_sb_cnt got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (base < obs_q.size()) ? obs_q[base] : 'x; base++;
      total++; if (o !== e) begin bad++; $display("FAIL flush_sb got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    int base = obs_q.size();
    logic [36:0] e, o;
    for (int i = 0; i < NS; i++) drive(i, 1'b1, 1'b1, 5'(20 + i), 32'(32'h300 + i));
    exp_q.push_back({5'd20, 32'h300});
    @(negedge clk);
    idle_all();
    @(negedge clk);
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", wen); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({wen, addr, wdat, busy, ready} !== '0) begin bad++;
      $display("FAIL arst_out got=%h exp=0", {wen, addr, wdat, busy, ready}); end
    total++; if ({fwd_en, fwd_addr, fwd_dat} !== '0) begin bad++;
      $display("FAIL arst_fwd got=%h exp=0", {fwd_en, fwd_addr, fwd_dat}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({wen, busy, ready} !== 6'b00_1111) begin bad++;
      $display("FAIL arst_release got=%b exp=001111", {wen, busy, ready}); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (obs_q.size() - base !== exp_q.size()) begin bad++;
      $display("FAIL arst_sb_cnt got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (base < obs_q.size()) ? obs_q[base] : 'x; base++;
      total++; if (o !== e) begin bad++; $display("FAIL arst_sb got=%h exp=%h", o, e); end
    end
  endtask

  initial begin
    idle_all();
    r_valid = '0; r_we = '0; r_rd = '0; r_data = '0;
    test_reset();
    test_single();
    test_discard();
    test_fixed_prio();
    test_backpressure();
    test_round_robin();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
